// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: state encoding and master count.
// No logic, no latency.
// No backpressure behaviour of its own.
package wb_arb_pkg;

  typedef enum bit [1:0] {
    A_IDLE = 2'd0,
    A_GNT0 = 2'd1,
    A_GNT1 = 2'd2
  } arb_state_t;

  localparam int NMASTERS = 2;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter (m0 = ifetch, m1 = data) onto the cache inbus; round-robin per tenure.
// One idle cycle of arbitration latency, then a combinational pass-through for the granted master.
// Granted master sees outbus stall, plus stall once MAXOUT requests are unacked; the other master is held stalled.
// Config macro: WB_ARB_FIXED_PRIO_EN makes m0 win every tie instead of alternating.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int MAXOUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master 0 (instruction fetch)
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [AWIDTH-1:0]   m0_adr_i,
  input  logic [DWIDTH-1:0]   m0_dat_i,
  input  logic [DWIDTH/8-1:0] m0_sel_i,
  output logic                m0_ack_o,
  output logic                m0_stall_o,
  output logic [DWIDTH-1:0]   m0_dat_o,
  // master 1 (data)
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [AWIDTH-1:0]   m1_adr_i,
  input  logic [DWIDTH-1:0]   m1_dat_i,
  input  logic [DWIDTH/8-1:0] m1_sel_i,
  output logic                m1_ack_o,
  output logic                m1_stall_o,
  output logic [DWIDTH-1:0]   m1_dat_o,
  // shared slave port towards the cache
  output logic                outbus_cyc_o,
  output logic                outbus_stb_o,
  output logic                outbus_we_o,
  output logic [AWIDTH-1:0]   outbus_adr_o,
  output logic [DWIDTH-1:0]   outbus_dat_o,
  output logic [DWIDTH/8-1:0] outbus_sel_o,
  input  logic                outbus_ack_i,
  input  logic                outbus_stall_i,
  input  logic [DWIDTH-1:0]   outbus_dat_i
);

  localparam int CW = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] MAXCNT = CW'(MAXOUT);

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;   // index of the master that owned the previous tenure
  logic [CW-1:0] cnt_q, cnt_d;     // accepted but not yet acked requests
  logic          full;
  logic          req_acc;
  logic          ack_dec;

  assign full    = (cnt_q == MAXCNT);
  assign req_acc = outbus_stb_o & ~outbus_stall_i;
  assign ack_dec = outbus_ack_i & (cnt_q != '0);

  // State, last-owner and outstanding-count registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= A_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate in idle, hold the grant until the owner drops cyc
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      A_IDLE: begin
        // late acks are dropped here; the count restarts from zero each tenure
        cnt_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_FIXED_PRIO_EN
          state_d = A_GNT0;
`else
          state_d = last_q ? A_GNT0 : A_GNT1;
`endif
        end else if (m0_cyc_i) begin
          state_d = A_GNT0;
        end else if (m1_cyc_i) begin
          state_d = A_GNT1;
        end
      end
      A_GNT0, A_GNT1: begin
        if (req_acc && !ack_dec) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!req_acc && ack_dec) begin
          cnt_d = cnt_q - CW'(1);
        end
        if ((state_q == A_GNT0) && !m0_cyc_i) begin
          state_d = A_IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if ((state_q == A_GNT1) && !m1_cyc_i) begin
          state_d = A_IDLE;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = A_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output mux: route the granted master to the outbus; reset forces the idle view at once
  always_comb begin
    outbus_cyc_o = 1'b0;
    outbus_stb_o = 1'b0;
    outbus_we_o  = 1'b0;
    outbus_adr_o = '0;
    outbus_dat_o = '0;
    outbus_sel_o = '0;
    m0_ack_o     = 1'b0;
    m0_stall_o   = 1'b1;
    m0_dat_o     = '0;
    m1_ack_o     = 1'b0;
    m1_stall_o   = 1'b1;
    m1_dat_o     = '0;
    if (!rst_i && (state_q == A_GNT0)) begin
      outbus_cyc_o = m0_cyc_i;
      outbus_stb_o = m0_stb_i & ~full;
      outbus_we_o  = m0_we_i;
      outbus_adr_o = m0_adr_i;
      outbus_dat_o = m0_dat_i;
      outbus_sel_o = m0_sel_i;
      m0_stall_o   = outbus_stall_i | full;
      m0_ack_o     = outbus_ack_i;
      m0_dat_o     = outbus_dat_i;
    end else if (!rst_i && (state_q == A_GNT1)) begin
      outbus_cyc_o = m1_cyc_i;
      outbus_stb_o = m1_stb_i & ~full;
      outbus_we_o  = m1_we_i;
      outbus_adr_o = m1_adr_i;
      outbus_dat_o = m1_dat_i;
      outbus_sel_o = m1_sel_i;
      m1_stall_o   = outbus_stall_i | full;
      m1_ack_o     = outbus_ack_i;
      m1_dat_o     = outbus_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: scenario tasks with randomized addresses/data/request patterns,
// expectations from a small model (last tenure owner, outstanding = accepted - acked).
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_wb_arbiter2;

  localparam int MAXOUT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_stall;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_stall;
  logic        ob_cyc, ob_stb, ob_we;
  logic [31:0] ob_adr, ob_wdat, ob_rdat;
  logic [3:0]  ob_sel;
  logic        ob_ack, ob_stall;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last;  // owner of the previous tenure; 1 after reset

  wb_arbiter2 #(.AWIDTH(32), .DWIDTH(32), .MAXOUT(MAXOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
    .m1_dat_o(m1_rdat),
    .outbus_cyc_o(ob_cyc), .outbus_stb_o(ob_stb), .outbus_we_o(ob_we),
    .outbus_adr_o(ob_adr), .outbus_dat_o(ob_wdat), .outbus_sel_o(ob_sel),
    .outbus_ack_i(ob_ack), .outbus_stall_i(ob_stall), .outbus_dat_i(ob_rdat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
    ob_ack = 0; ob_stall = 0; ob_rdat = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1;
    idle_inputs();
    tick();
    tick();
    rst_i = 0;
    model_last = 1;
  endtask

  task automatic test_reset();
    do_reset();
    ob_rdat = 32'hA5A5_0001;
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, ob_stb, ob_we} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {ob_cyc, ob_stb, ob_we});
    else n_pass++;
    n_checks++;
    if ({ob_adr, ob_wdat, ob_sel} !== 68'd0) $display("FAIL reset_bus: got adr %h dat %h sel %h want 0", ob_adr, ob_wdat, ob_sel);
    else n_pass++;
    n_checks++;
    if ({m0_ack, m0_stall, m1_ack, m1_stall} !== 4'b0101) $display("FAIL reset_mstr: got %b want 0101", {m0_ack, m0_stall, m1_ack, m1_stall});
    else n_pass++;
    n_checks++;
    if ({m0_rdat, m1_rdat} !== 64'd0) $display("FAIL reset_rdat: got %h %h want 0", m0_rdat, m1_rdat);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_read();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hF; ob_stall = 0;
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, m0_stall} !== 2'b01) $display("FAIL rd_arb_latency: got cyc,stall %b want 01", {ob_cyc, m0_stall});
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, ob_stb, ob_we, ob_adr, m0_stall} !== {3'b110, 32'h100, 1'b0})
      $display("FAIL rd_grant: got cyc %b stb %b we %b adr %h stall %b want 1 1 0 100 0", ob_cyc, ob_stb, ob_we, ob_adr, m0_stall);
    else n_pass++;
    tick();
    m0_stb = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (m0_ack !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", m0_ack);
      else n_pass++;
      tick();
    end
    ob_ack = 1; ob_rdat = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({m0_ack, m0_rdat, m1_ack, m1_rdat} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'd0})
      $display("FAIL rd_ack: got m0 %b/%h m1 %b/%h want 1/deadbeef 0/0", m0_ack, m0_rdat, m1_ack, m1_rdat);
    else n_pass++;
    tick();
    ob_ack = 0; m0_cyc = 0;
    @(negedge clk);
    n_checks++;
    if (ob_cyc !== 1'b0) $display("FAIL rd_release: got %b want 0", ob_cyc);
    else n_pass++;
    tick();
    model_last = 0;
  endtask

  task automatic test_round_robin();
    int          req;
    int          w;
    logic [31:0] a0, a1;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      req = (t < 4) ? 3 : $urandom_range(1, 3);
      if (req == 3) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (model_last == 1) ? 0 : 1;
`endif
      end else begin
        w = (req == 1) ? 0 : 1;
      end
      a0 = $urandom; a1 = $urandom;
      m0_cyc = req[0]; m0_stb = req[0]; m0_adr = a0; m0_sel = 4'hF;
      m1_cyc = req[1]; m1_stb = req[1]; m1_adr = a1; m1_sel = 4'h3;
      @(negedge clk);
      n_checks++;
      if (ob_cyc !== 1'b0) $display("FAIL rr_idle_%0d: got cyc %b want 0", t, ob_cyc);
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({ob_adr, m0_stall, m1_stall} !== {(w == 1) ? a1 : a0, (w == 1) ? 2'b10 : 2'b01})
        $display("FAIL rr_grant_%0d: got adr %h stalls %b%b want master %0d", t, ob_adr, m0_stall, m1_stall, w);
      else n_pass++;
      tick();
      m0_stb = 0; m1_stb = 0; ob_ack = 1; ob_rdat = $urandom;
      @(negedge clk);
      n_checks++;
      if ({m0_ack, m1_ack} !== ((w == 1) ? 2'b01 : 2'b10))
        $display("FAIL rr_ack_route_%0d: got %b%b want master %0d", t, m0_ack, m1_ack, w);
      else n_pass++;
      tick();
      ob_ack = 0; m0_cyc = 0; m1_cyc = 0;
      tick();
      model_last = w;
    end
  endtask

  task automatic test_maxout();
    logic [31:0] adrs[6];
    logic [31:0] dats[6];
    int          acc_cyc[6];
    int          acc, acked, mcnt, cyc;
    logic        full;
    for (int i = 0; i < 6; i++) begin
      adrs[i] = $urandom; dats[i] = $urandom;
    end
    acc = 0; acked = 0; mcnt = 0; cyc = 0;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_adr = adrs[0]; m1_wdat = dats[0];
    ob_stall = 0; ob_ack = 0;
    tick();
    while (acked < 6 && cyc < 60) begin
      @(negedge clk);
      full = (mcnt == MAXOUT);
      n_checks++;
      if (m1_stall !== (ob_stall | full)) $display("FAIL mo_stall_c%0d: got %b want %b", cyc, m1_stall, ob_stall | full);
      else n_pass++;
      n_checks++;
      if (ob_stb !== (m1_stb & ~full)) $display("FAIL mo_stb_c%0d: got %b want %b", cyc, ob_stb, m1_stb & ~full);
      else n_pass++;
      n_checks++;
      if ({m1_ack, m0_ack} !== {ob_ack, 1'b0}) $display("FAIL mo_ack_c%0d: got m1 %b m0 %b want %b 0", cyc, m1_ack, m0_ack, ob_ack);
      else n_pass++;
      if (ob_stb && !ob_stall) begin
        n_checks++;
        if ({ob_we, ob_adr, ob_wdat} !== {1'b1, adrs[acc], dats[acc]})
          $display("FAIL mo_order_%0d: got %h/%h want %h/%h", acc, ob_adr, ob_wdat, adrs[acc], dats[acc]);
        else n_pass++;
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (ob_ack) acked++;
      mcnt = acc - acked;
      tick();
      cyc++;
      m1_stb = (acc < 6);
      if (acc < 6) begin
        m1_adr = adrs[acc]; m1_wdat = dats[acc];
      end
      ob_stall = ($urandom_range(0, 3) == 0);
      ob_ack = (acked < acc) && (cyc >= acc_cyc[acked] + 5);
    end
    n_checks++;
    if ({acc, acked} !== {32'd6, 32'd6}) $display("FAIL mo_complete: got %0d accepted %0d acked want 6 6", acc, acked);
    else n_pass++;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; ob_ack = 0; ob_stall = 0;
    tick();
    tick();
    model_last = 1;
  endtask

  task automatic test_hold();
    logic [31:0] a;
    a = $urandom;
    m1_cyc = 1; m1_stb = 0; ob_stall = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = a;
    for (int i = 0; i < 20; i++) begin
      ob_ack = $urandom_range(0, 1);
      @(negedge clk);
      n_checks++;
      if ({ob_cyc, m0_ack, m0_stall, m1_ack} !== {3'b101, ob_ack})
        $display("FAIL hold_c%0d: got cyc %b m0 ack %b stall %b m1 ack %b want 1 0 1 %b", i, ob_cyc, m0_ack, m0_stall, m1_ack, ob_ack);
      else n_pass++;
      tick();
    end
    ob_ack = 0; m1_cyc = 0;
    @(negedge clk);
    n_checks++;
    if (ob_cyc !== 1'b0) $display("FAIL hold_drop: got cyc %b want 0", ob_cyc);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, m0_stall} !== 2'b01) $display("FAIL hold_idle: got cyc,stall %b want 01", {ob_cyc, m0_stall});
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, ob_adr, m0_stall} !== {1'b1, a, 1'b0}) $display("FAIL hold_m0_grant: got cyc %b adr %h stall %b want 1 %h 0", ob_cyc, ob_adr, m0_stall, a);
    else n_pass++;
    tick();
    m0_stb = 0; m0_cyc = 0;
    tick();
    tick();
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom; ob_stall = 0; ob_ack = 0;
    tick();
    tick();
    tick();
    m0_stb = 0; rst_i = 1;
    @(negedge clk);
    n_checks++;
    if (ob_cyc !== 1'b0) $display("FAIL rst_mid_cyc: got %b want 0", ob_cyc);
    else n_pass++;
    tick();
    rst_i = 0; ob_ack = 1; ob_rdat = $urandom;
    model_last = 1;
    @(negedge clk);
    n_checks++;
    if ({ob_cyc, m0_ack, m1_ack} !== 3'b000) $display("FAIL rst_late_ack: got cyc %b acks %b%b want 0 00", ob_cyc, m0_ack, m1_ack);
    else n_pass++;
    tick();
    ob_ack = 0; m0_stb = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_stall, ob_stb} !== ((k == 4) ? 2'b10 : 2'b01))
        $display("FAIL rst_cnt_clear_%0d: got stall,stb %b want %b", k, {m0_stall, ob_stb}, (k == 4) ? 2'b10 : 2'b01);
      else n_pass++;
      tick();
    end
    m0_stb = 0; m0_cyc = 0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_maxout();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
